// File: rtl/nibble_add_seq.sv
// nibble_add_seq: W-bit (W = 4*NIB) add/subtract built on one shared external 4-bit adder,
// processing one nibble per clock, least-significant nibble first.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             operation request, sampled only while idle
//   sub, cin          0: op_a + op_b + cin; 1: op_a - op_b (cin ignored)
//   op_a, op_b        operands, latched on accept
//   busy              high while running and in the done cycle
//   done              one-cycle pulse; result/cout/ovf valid
//   result, cout, ovf sum/difference, final carry (1 = no borrow on subtract), signed overflow
//   add_a, add_b,
//   add_cin           drive the external adder, zero when not running
//   add_sum, add_cout combinational results from the external adder
module nibble_add_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [4*NIB-1:0]   op_a,
    input  logic [4*NIB-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [4*NIB-1:0]   result,
    output logic               cout,
    output logic               ovf,
    output logic [3:0]         add_a,
    output logic [3:0]         add_b,
    output logic               add_cin,
    input  logic [3:0]         add_sum,
    input  logic               add_cout
);

    localparam int unsigned W    = 4 * NIB;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q;
    logic [W-1:0]    a_q, b_q, result_q;
    logic            carry_q, cout_q, ovf_q;
    logic            last_nib;

    assign last_nib = (idx_q == LastIdx);

    // Next state and outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                busy    = 1'b1;
                add_a   = a_q[{idx_q, 2'b00} +: 4];
                add_b   = b_q[{idx_q, 2'b00} +: 4];
                add_cin = carry_q;
                if (last_nib) state_d = StDone;
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand latch, per-nibble capture, final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                a_q      <= op_a;
                // Subtract as a + ~b + 1.
                b_q      <= sub ? ~op_b : op_b;
                carry_q  <= sub ? 1'b1 : cin;
                result_q <= '0;
                idx_q    <= '0;
            end else if (state_q == StRun) begin
                result_q[{idx_q, 2'b00} +: 4] <= add_sum;
                carry_q <= add_cout;
                idx_q   <= idx_q + IdxW'(1);
                if (last_nib) begin
                    cout_q <= add_cout;
                    // Same-sign operands whose top result bit differs from them.
                    ovf_q  <= (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
                    idx_q  <= '0;
                end
            end
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, done, cout, ovf, add_cin, add_cout;
    logic [15:0] result;
    logic [3:0]  add_a, add_b, add_sum;

    nibble_add_seq #(.NIB(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External 4-bit fast adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [17:0] exp_q[$];
    int done_cycles[$];

    task automatic check(input string name, input bit ok, input logic [31:0] act,
                         input logic [31:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Scoreboard monitor: every done pulse pops one expected {result, cout, ovf}.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b0, {14'b0, result, cout, ovf}, 32'h0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("scoreboard", {result, cout, ovf} == e, {14'b0, result, cout, ovf},
                      {14'b0, e});
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic c, input logic [15:0] er, input logic ec,
                          input logic eo, output int busy_cnt, output int done_at,
                          output logic [3:0] cin_seq);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        exp_q.push_back({er, ec, eo});
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble operands after accept; the latched values must be used.
        op_a = ~a; op_b = ~b; cin = ~c; sub = ~s;
        busy_cnt = 0; done_at = 0; cin_seq = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
            if (k <= 4 && busy && !done) cin_seq[k-1] = add_cin;
            if (!busy) break;
        end
        if (busy) check("op_timeout", 1'b0, 32'(busy), 32'h0);
    endtask

    int bc, da, nd;
    logic [3:0] cs;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {busy, done, result, cout, ovf, add_a, add_b, add_cin} == 30'h0,
              {2'b0, busy, done, result, cout, ovf, add_a, add_b, add_cin}, 32'h0);
        rst_n = 1'b1;

        // 1: basic add, busy length and done latency.
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, bc, da, cs);
        check("busy_cycles", bc == 5, bc, 5);
        check("done_latency", da == 5, da, 5);

        // 2: carry ripple through all nibbles.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, bc, da, cs);
        check("cin_sequence", cs == 4'b1110, cs, 4'b1110);

        // 3a: subtract with overflow; cin ignored.
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, bc, da, cs);
        check("sub_first_cin", cs[0] == 1'b1, cs[0], 1);

        // 6: asynchronous reset after two RUN cycles (cout/ovf are 1 beforehand).
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = done_cycles.size();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs",
              {busy, done, result, cout, ovf, add_a, add_b, add_cin} == 30'h0,
              {2'b0, busy, done, result, cout, ovf, add_a, add_b, add_cin}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cycles.size() == nd, done_cycles.size(), nd);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, bc, da, cs);

        // 3b, 4a, 4b.
        run_op(16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, bc, da, cs);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, bc, da, cs);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, bc, da, cs);

        // 5: start held high; op_a changed during the first RUN.
        @(negedge clk);
        nd = done_cycles.size();
        op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        exp_q.push_back({16'h3333, 1'b0, 1'b0});
        exp_q.push_back({16'h6222, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        op_a = 16'h4000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done_cycles.size() >= nd + 2) break;
        end
        start = 1'b0;
        if (done_cycles.size() >= nd + 2)
            check("b2b_spacing", done_cycles[nd+1] - done_cycles[nd] == 6,
                  done_cycles[nd+1] - done_cycles[nd], 6);
        else
            check("b2b_timeout", 1'b0, done_cycles.size() - nd, 2);
        repeat (4) @(negedge clk);
        check("idle_after_b2b", busy == 1'b0, busy, 0);
        check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Sequencer that performs 4*NIB-bit add/subtract by time-multiplexing one external 4-bit fast adder (fast_adder4), one nibble per clock, LSB nibble first.
- Latches operands on a start request, drives the adder's a/b/c_in each cycle and captures sum/c_out.
- Reports result, carry-out and signed overflow with a one-cycle done pulse.
- Sits between a requesting control unit and the shared 4-bit adder datapath.

Parameters:
- NIB, 4, nibbles per operand; operand width W = 4*NIB; legal range NIB >= 1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request; sampled only in IDLE
- sub  in  1  0 = op_a + op_b + cin; 1 = op_a - op_b (cin ignored)
- cin  in  1  carry-in for add
- op_a  in  W  operand A
- op_b  in  W  operand B
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result/cout/ovf valid
- result  out  W  sum/difference
- cout  out  1  final carry-out; for subtract, 1 = no borrow
- ovf  out  1  two's-complement overflow
- add_a  out  4  to adder a
- add_b  out  4  to adder b
- add_cin  out  1  to adder c_in
- add_sum  in  4  from adder sum (combinational)
- add_cout  in  1  from adder c_out (combinational)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, nibble index 0. Outputs busy, done, result, cout, ovf, add_a, add_b, add_cin all 0. Internal operand and carry registers 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - When start=1 at a clock edge: a_reg <= op_a; b_reg <= sub ? ~op_b : op_b; carry <= sub ? 1 : cin; result <= 0; idx <= 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Adder inputs: add_a = a_reg[4*idx+3:4*idx]; add_b = b_reg nibble idx; add_cin = carry.
  - At each edge: result nibble idx <= add_sum; carry <= add_cout; idx <= idx+1.
  - At the edge where idx == NIB-1: cout <= add_cout; ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]); go to DONE.
- DONE: done=1 for exactly this cycle; unconditionally return to IDLE at the next edge.
- Adder inputs add_a, add_b and add_cin are 0 outside RUN.
- Latency: start accepted at edge E0; RUN occupies the NIB cycles after E0; done is high in the cycle following edge E_NIB. Start-to-done is NIB+1 cycles; the next accept is possible at edge E_NIB+2.
- start is ignored in RUN and DONE; holding start high causes back-to-back operations separated by one IDLE cycle.
- Operand inputs may change after acceptance without effect.
- result, cout and ovf hold their values after DONE until the next accept clears result. cout and ovf update only at the final nibble.
- NIB=1: RUN lasts one cycle and the overflow is taken from that nibble.
- Arithmetic is modulo 2^W; the carry out of nibble NIB-1 goes only to cout.
- Reset mid-RUN or in DONE: the operation is aborted with no done pulse, and all outputs return to reset values.

Test Plan:
1. NIB=4, add 0x1234 + 0x0FFF, cin=0 → result 0x2233, cout=0, ovf=0. busy high 5 cycles; done exactly 5 cycles after the accept edge.
2. Add 0xFFFF + 0x0001, cin=0 → result 0x0000, cout=1, ovf=0. Per-cycle add_cin sequence is 0,1,1,1.
3. Sub 0x8000 - 0x0001 with cin=1 → result 0x7FFF, cout=1, ovf=1. The first-cycle add_cin=1 ignores cin. Sub 0x0001 - 0x0002 → 0xFFFF, cout=0, ovf=0.
4. Add 0x7FFF + 0x0001 → 0x8000, ovf=1, cout=0. Add 0x0000 + 0x0000 with cin=1 → 0x0001.
5. start held high continuously → ops accepted every 6 cycles. op_a is changed during RUN → result unaffected.
6. rst_n pulsed low after 2 RUN cycles → outputs 0 immediately (asynchronous), no done pulse. Next op 0x00FF + 0x0001 → 0x0100.
